// File: rtl/bcd_to_binary.sv
// Sequential packed-BCD to binary converter (reverse double-dabble, one bit per clock).
// Optional input digit validation is enabled by defining BCD_DIGIT_CHECK_EN.
module bcd_to_binary #(
  parameter int DIGITS = 2,
  parameter int BIN_W  = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic [BIN_W-1:0]      binary,
  output logic                  error
);

  localparam int BCD_W  = 4 * DIGITS;
  localparam int WORK_W = BCD_W + BIN_W;
  localparam int CNT_W  = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [WORK_W-1:0]   work_q, work_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [BIN_W-1:0]    binary_q, binary_d;
  logic                err_q, err_d;
  logic [WORK_W-1:0]   shifted;

  // Shift right, then pull every digit that landed at >=8 back by 3 (no inter-digit carry).
  always_comb begin
    shifted = work_q >> 1;
    for (int d = 0; d < DIGITS; d++) begin
      if (shifted[BIN_W+4*d +: 4] >= 4'd8)
        shifted[BIN_W+4*d +: 4] = shifted[BIN_W+4*d +: 4] - 4'd3;
    end
  end

`ifdef BCD_DIGIT_CHECK_EN
  logic bcd_bad;
  always_comb begin
    bcd_bad = 1'b0;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd_in[4*d +: 4] > 4'd9) bcd_bad = 1'b1;
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    binary_d = binary_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          work_d  = {bcd_in, {BIN_W{1'b0}}};
          cnt_d   = '0;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = SHIFT;
`ifdef BCD_DIGIT_CHECK_EN
          if (bcd_bad) begin
            err_d   = 1'b1;
            state_d = FINISH;
          end
`endif
        end
      end
      SHIFT: begin
        work_d = shifted;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(BIN_W - 1)) state_d = FINISH;
      end
      FINISH: begin
        // An aborted conversion leaves the previous result visible.
        if (!err_q) binary_d = work_q[BIN_W-1:0];
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      work_q   <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      binary_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      binary_q <= binary_d;
      err_q    <= err_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign binary = binary_q;
  assign error  = err_q;

endmodule
